// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 frame constants, receive FSM encoding, parity helper.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   // Parity bit that makes data plus parity contain an odd number of ones.
   function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
      return ~(^d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_clk_filter
// Purpose  : Synchronises PS/2 clock/data, deglitches the clock, strobes falls.
// Revision : 1.0
// ============================================================================
module ps2_clk_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic fall_o,
   output logic data_o
);

   localparam int             CW         = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]  c_CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   filt_q;
   logic                   fall_q;
   logic                   w_clk_s;

   assign w_clk_s = clk_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         cnt_q       <= '0;
         filt_q      <= 1'b1;
         fall_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         fall_q      <= 1'b0;
         // Level flips only after FILTER_LEN consecutive disagreeing samples.
         if (w_clk_s == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == c_CNT_LAST) begin
            cnt_q  <= '0;
            filt_q <= w_clk_s;
            fall_q <= ~w_clk_s;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign fall_o = fall_q;
   assign data_o = data_sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_frame
// Purpose  : Host-side PS/2 device-to-host frame receiver with parity/timeout.
// Revision : 1.0
// ============================================================================
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   input  logic                     rx_en,
   output logic [PS2_DATA_BITS-1:0] rx_data,
   output logic                     rx_valid,
   output logic                     rx_err,
   output logic                     rx_timeout,
   output logic                     busy
);

   localparam int            TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]    c_BIT_LAST = 3'(PS2_DATA_BITS - 1);

   logic                     w_fall;
   logic                     w_data;

   logic [1:0]               state_q,  state_d;
   logic [2:0]               bit_q,    bit_d;
   logic [PS2_DATA_BITS-1:0] shift_q,  shift_d;
   logic                     par_q,    par_d;
   logic [TW-1:0]            tmo_q,    tmo_d;
   logic [PS2_DATA_BITS-1:0] data_q,   data_d;
   logic                     valid_q,  valid_d;
   logic                     err_q,    err_d;
   logic                     to_q,     to_d;

   ps2_clk_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .fall_o     (w_fall),
      .data_o     (w_data)
   );

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tmo_d   = tmo_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;

      // Losing the bus outranks everything, including a coincident stop bit.
      if (!rx_en) begin
         state_d = ST_IDLE;
         tmo_d   = '0;
      end else if (w_fall) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!w_data) begin
                  state_d = ST_DATA;
                  bit_d   = '0;
                  par_d   = 1'b0;
               end
            end
            ST_DATA: begin
               shift_d[bit_q] = w_data;
               bit_d          = bit_q + 3'd1;
               if (bit_q == c_BIT_LAST) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               par_d   = w_data;
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (w_data && (par_q == odd_parity(shift_q))) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == c_TMO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            to_d    = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tmo_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tmo_q   <= tmo_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign rx_err     = err_q;
   assign rx_timeout = to_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
